// File: rtl/lr35902_dbg_pkg.sv
// lr35902_dbg_pkg: shared command codes, sequencer states and sizing defaults for the debug sequencer
package lr35902_dbg_pkg;

   localparam int DBG_DEPTH  = 24;
   localparam int DBG_SETTLE = 24;

   typedef enum logic [1:0] {
      OP_HALT  = 2'd0,
      OP_RUN   = 2'd1,
      OP_STEP  = 2'd2,
      OP_NOINC = 2'd3
   } dbg_op_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_STEP   = 2'd2,
      S_FIN    = 2'd3
   } dbg_state_e;

endpackage

// File: rtl/lr35902_dbg_buf.sv
// lr35902_dbg_buf: injection script RAM and probe capture RAM, both with registered reads
module lr35902_dbg_buf #(
   parameter int DEPTH = 24,
   parameter int AW    = 5
) (
   input  logic          cpu_clk,
   input  logic          reset,
   input  logic          scr_we_i,
   input  logic [AW-1:0] scr_waddr_i,
   input  logic [8:0]    scr_wdata_i,
   input  logic          scr_re_i,
   input  logic [AW-1:0] scr_raddr_i,
   output logic [8:0]    scr_rdata_o,
   input  logic          cap_we_i,
   input  logic [AW-1:0] cap_waddr_i,
   input  logic [7:0]    cap_wdata_i,
   input  logic [AW-1:0] cap_raddr_i,
   output logic [7:0]    cap_rdata_o
);

   logic [8:0] scr_mem [DEPTH];
   logic [7:0] cap_mem [DEPTH];
   logic [8:0] scr_rdata_q;
   logic [7:0] cap_rdata_q;

   // Memory writes; addresses beyond the table are dropped
   always_ff @(posedge cpu_clk) begin
      if (scr_we_i && int'(scr_waddr_i) < DEPTH) scr_mem[scr_waddr_i] <= scr_wdata_i;
      if (cap_we_i && int'(cap_waddr_i) < DEPTH) cap_mem[cap_waddr_i] <= cap_wdata_i;
   end

   // Script read register doubles as the drv/data output stage, so it clears on reset and holds when idle
   always_ff @(posedge cpu_clk) begin
      if (reset) scr_rdata_q <= '0;
      else if (scr_re_i) scr_rdata_q <= int'(scr_raddr_i) < DEPTH ? scr_mem[scr_raddr_i] : '0;
   end

   // Capture read port, free-running; a same-cycle write is seen on the following read
   always_ff @(posedge cpu_clk) begin
      cap_rdata_q <= int'(cap_raddr_i) < DEPTH ? cap_mem[cap_raddr_i] : '0;
   end

   assign scr_rdata_o = scr_rdata_q;
   assign cap_rdata_o = cap_rdata_q;

endmodule

// File: rtl/lr35902_dbg_seq.sv
// lr35902_dbg_seq: cycle-level debug sequencer owning the CPU halt/no_inc/drv/data controls
module lr35902_dbg_seq
   import lr35902_dbg_pkg::*;
#(
   parameter int DEPTH         = DBG_DEPTH,
   parameter int AW            = $clog2(DEPTH),
   parameter int SETTLE        = DBG_SETTLE,
   parameter bit HALT_ON_RESET = 1'b1
) (
   input  logic          cpu_clk,
   input  logic          reset,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic [1:0]    cmd_op_i,
   input  logic [AW-1:0] cmd_arg_i,
   input  logic          scr_we_i,
   input  logic [AW-1:0] scr_addr_i,
   input  logic [8:0]    scr_wdata_i,
   input  logic [AW-1:0] cap_addr_i,
   output logic [7:0]    cap_rdata_o,
   input  logic          break_in_i,
   input  logic [7:0]    probe_i,
   output logic          halt_o,
   output logic          no_inc_o,
   output logic          drv_o,
   output logic [7:0]    data_o,
   output logic          halted_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic          brk_o
);

   localparam int CW = $clog2(SETTLE > DEPTH ? SETTLE : DEPTH);

   dbg_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] len_q, len_d;
   logic          halt_q, halt_d, halted_q, halted_d, no_inc_q, no_inc_d;
   logic          err_pend_q, err_pend_d, brk_pend_q, brk_pend_d;
   logic          done_q, done_d, err_q, err_d, brk_q, brk_d;
   logic          brk_req, accept, scr_re;
   logic [AW-1:0] scr_raddr;
   logic [8:0]    scr_rdata;

   assign brk_req     = break_in_i & ~halt_q;
   assign cmd_ready_o = (state_q == S_IDLE) & ~brk_req;
   assign accept      = cmd_valid_i & cmd_ready_o;

   // Next-state logic; the script is prefetched one entry ahead so drv/data are registered for step cycle k
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      halt_d     = halt_q;
      halted_d   = halted_q;
      no_inc_d   = no_inc_q;
      err_pend_d = err_pend_q;
      brk_pend_d = brk_pend_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      brk_d      = 1'b0;
      scr_re     = 1'b0;
      scr_raddr  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (brk_req) begin
               halt_d     = 1'b1;
               cnt_d      = '0;
               state_d    = S_SETTLE;
               brk_pend_d = 1'b1;
               err_pend_d = 1'b0;
            end else if (accept) begin
               state_d    = S_FIN;
               err_pend_d = 1'b0;
               brk_pend_d = 1'b0;
               unique case (dbg_op_e'(cmd_op_i))
                  OP_HALT: begin
                     if (!halted_q) begin
                        halt_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                     end
                  end
                  OP_RUN: begin
                     halt_d   = 1'b0;
                     no_inc_d = 1'b0;
                     halted_d = 1'b0;
                  end
                  OP_NOINC: begin
                     if (halted_q) no_inc_d = cmd_arg_i[0];
                     else err_pend_d = 1'b1;
                  end
                  OP_STEP: begin
                     if (!halted_q || cmd_arg_i > AW'(DEPTH - 1)) err_pend_d = 1'b1;
                     else begin
                        state_d = S_STEP;
                        cnt_d   = '0;
                        len_d   = cmd_arg_i;
                        halt_d  = 1'b0;
                        scr_re  = 1'b1;
                     end
                  end
               endcase
            end
         end
         S_SETTLE: begin
            if (cnt_q == CW'(SETTLE - 1)) begin
               halted_d = 1'b1;
               state_d  = S_FIN;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_STEP: begin
            halt_d    = 1'b1;
            scr_raddr = AW'(cnt_q + 1'b1);
            if (cnt_q == CW'(len_q)) state_d = S_FIN;
            else begin
               cnt_d  = cnt_q + 1'b1;
               scr_re = 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = err_pend_q;
            brk_d   = brk_pend_q;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         halt_q     <= HALT_ON_RESET;
         halted_q   <= HALT_ON_RESET;
         no_inc_q   <= 1'b0;
         err_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         brk_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         halt_q     <= halt_d;
         halted_q   <= halted_d;
         no_inc_q   <= no_inc_d;
         err_pend_q <= err_pend_d;
         brk_pend_q <= brk_pend_d;
         done_q     <= done_d;
         err_q      <= err_d;
         brk_q      <= brk_d;
      end
   end

   lr35902_dbg_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .cpu_clk     (cpu_clk),
      .reset       (reset),
      .scr_we_i    (scr_we_i & (state_q != S_STEP)),
      .scr_waddr_i (scr_addr_i),
      .scr_wdata_i (scr_wdata_i),
      .scr_re_i    (scr_re),
      .scr_raddr_i (scr_raddr),
      .scr_rdata_o (scr_rdata),
      .cap_we_i    (state_q == S_STEP),
      .cap_waddr_i (AW'(cnt_q)),
      .cap_wdata_i (probe_i),
      .cap_raddr_i (cap_addr_i),
      .cap_rdata_o (cap_rdata_o)
   );

   assign halt_o   = halt_q;
   assign no_inc_o = no_inc_q;
   assign drv_o    = (state_q == S_STEP) & scr_rdata[8];
   assign data_o   = scr_rdata[7:0];
   assign halted_o = halted_q;
   assign busy_o   = state_q != S_IDLE;
   assign done_o   = done_q;
   assign err_o    = err_q;
   assign brk_o    = brk_q;

endmodule

// File: tb/tb_lr35902_dbg_seq.sv
// tb_lr35902_dbg_seq: directed and randomized checks of the debug sequencer against a script/capture model
module tb_lr35902_dbg_seq;
   import lr35902_dbg_pkg::*;

   localparam int DEPTH = 24;
   localparam int AW    = 5;

   logic          cpu_clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0, cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [AW-1:0] cmd_arg = '0;
   logic          scr_we = 1'b0;
   logic [AW-1:0] scr_addr = '0;
   logic [8:0]    scr_wdata = '0;
   logic [AW-1:0] cap_addr = '0;
   logic [7:0]    cap_rdata;
   logic          break_in = 1'b0;
   logic [7:0]    probe = '0;
   logic          halt, no_inc, drv, halted, busy, done, err, brk;
   logic [7:0]    data;

   int compared = 0;
   int mismatched = 0;

   logic [8:0] scr_m [DEPTH];
   logic [7:0] cap_m [DEPTH];
   bit         cap_v [DEPTH];

   lr35902_dbg_seq dut (
      .cpu_clk     (cpu_clk),
      .reset       (reset),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_op_i    (cmd_op),
      .cmd_arg_i   (cmd_arg),
      .scr_we_i    (scr_we),
      .scr_addr_i  (scr_addr),
      .scr_wdata_i (scr_wdata),
      .cap_addr_i  (cap_addr),
      .cap_rdata_o (cap_rdata),
      .break_in_i  (break_in),
      .probe_i     (probe),
      .halt_o      (halt),
      .no_inc_o    (no_inc),
      .drv_o       (drv),
      .data_o      (data),
      .halted_o    (halted),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err),
      .brk_o       (brk)
   );

   always #5 cpu_clk = ~cpu_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input int arg);
      int n = 0;
      cmd_op = op;
      cmd_arg = AW'(arg);
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         tick();
         n++;
      end
      chk("accept_timeout", n < 200, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int n);
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk(tag, n < 100, 1);
   endtask

   task automatic wr(input int a, input logic [8:0] d);
      scr_we = 1'b1;
      scr_addr = AW'(a);
      scr_wdata = d;
      tick();
      scr_we = 1'b0;
      if (a < DEPTH) scr_m[a] = d;
   endtask

   task automatic do_halt();
      int n;
      send(OP_HALT, 0);
      wait_done("halt_done_timeout", n);
      tick();
   endtask

   task automatic run_step(input int len);
      logic [7:0] pr;
      send(OP_STEP, len);
      for (int k = 0; k <= len; k++) begin
         chk("step_drv", drv, scr_m[k][8]);
         if (scr_m[k][8]) chk("step_data", data, scr_m[k][7:0]);
         chk("step_halt", halt, k != 0);
         chk("step_halted", halted, 1);
         pr = 8'($urandom);
         probe = pr;
         cap_m[k] = pr;
         cap_v[k] = 1'b1;
         scr_we = 1'b1;
         scr_addr = AW'($urandom_range(0, DEPTH - 1));
         scr_wdata = 9'($urandom);
         tick();
      end
      scr_we = 1'b0;
      chk("step_fin_drv", drv, 0);
      chk("step_fin_busy", busy, 1);
      chk("step_fin_done", done, 0);
      tick();
      chk("step_done", done, 1);
      chk("step_err", err, 0);
      chk("step_brk", brk, 0);
      tick();
      chk("step_done_pulse", done, 0);
   endtask

   task automatic rd_cap(input int a);
      cap_addr = AW'(a);
      tick();
      if (a >= DEPTH) chk("cap_oob", cap_rdata, 0);
      else if (cap_v[a]) chk("cap_data", cap_rdata, cap_m[a]);
   endtask

   initial begin
      int n;
      int len;
      for (int i = 0; i < DEPTH; i++) cap_v[i] = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_halt", halt, 1);
      chk("rst_halted", halted, 1);
      chk("rst_no_inc", no_inc, 0);
      chk("rst_drv", drv, 0);
      chk("rst_data", data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_brk", brk, 0);
      chk("rst_ready", cmd_ready, 1);
      tick();

      send(OP_RUN, 0);
      chk("run_halt", halt, 0);
      chk("run_done_early", done, 0);
      chk("run_busy", busy, 1);
      tick();
      chk("run_done", done, 1);
      chk("run_halted", halted, 0);
      chk("run_err", err, 0);
      tick();
      chk("run_done_pulse", done, 0);

      send(OP_HALT, 0);
      chk("halt_rise", halt, 1);
      chk("halt_halted_early", halted, 0);
      n = 0;
      while (!halted && n < 100) begin
         chk("halt_hold", halt, 1);
         tick();
         n++;
      end
      chk("halt_settle_cycles", n, 24);
      chk("halt_done_early", done, 0);
      tick();
      chk("halt_done", done, 1);
      chk("halt_brk", brk, 0);
      chk("halt_err", err, 0);
      tick();

      send(OP_HALT, 0);
      chk("rehalt_busy", busy, 1);
      chk("rehalt_done_early", done, 0);
      tick();
      chk("rehalt_done", done, 1);
      chk("rehalt_err", err, 0);
      chk("rehalt_halted", halted, 1);
      tick();

      wr(0, 9'h13E);
      wr(1, 9'h142);
      wr(2, 9'h000);
      for (int i = 3; i < DEPTH; i++) wr(i, 9'($urandom));
      run_step(2);
      for (int i = 0; i < 3; i++) rd_cap(i);

      send(OP_RUN, 0);
      tick();
      tick();
      send(OP_STEP, 1);
      chk("step_run_drv", drv, 0);
      chk("step_run_halt", halt, 0);
      tick();
      chk("step_run_done", done, 1);
      chk("step_run_err", err, 1);
      chk("step_run_drv2", drv, 0);
      chk("step_run_halt2", halt, 0);
      tick();
      send(OP_NOINC, 1);
      tick();
      chk("noinc_run_err", err, 1);
      chk("noinc_run_val", no_inc, 0);
      tick();

      do_halt();
      send(OP_STEP, 30);
      chk("step_oor_drv", drv, 0);
      chk("step_oor_halt", halt, 1);
      tick();
      chk("step_oor_done", done, 1);
      chk("step_oor_err", err, 1);
      chk("step_oor_drv2", drv, 0);
      chk("step_oor_halt2", halt, 1);
      tick();

      send(OP_RUN, 0);
      tick();
      tick();
      break_in = 1'b1;
      cmd_op = OP_RUN;
      cmd_arg = '0;
      cmd_valid = 1'b1;
      #1;
      chk("brk_ready", cmd_ready, 0);
      tick();
      break_in = 1'b0;
      chk("brk_halt", halt, 1);
      chk("brk_busy", busy, 1);
      wait_done("brk_done_timeout", n);
      chk("brk_cycles", n, 25);
      chk("brk_flag", brk, 1);
      chk("brk_err", err, 0);
      chk("brk_halted", halted, 1);
      chk("brk_ready_after", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      chk("brk_run_halt", halt, 0);
      chk("brk_run_busy", busy, 1);
      tick();
      chk("brk_run_done", done, 1);
      chk("brk_run_brk", brk, 0);
      chk("brk_run_halted", halted, 0);
      tick();

      do_halt();
      for (int it = 0; it < 8; it++) begin
         for (int w = 0; w < 6; w++) wr(int'($urandom_range(0, 31)), 9'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            len = int'($urandom_range(DEPTH, 31));
            send(OP_STEP, len);
            chk("rnd_oor_drv", drv, 0);
            chk("rnd_oor_halt", halt, 1);
            tick();
            chk("rnd_oor_done", done, 1);
            chk("rnd_oor_err", err, 1);
            tick();
         end else begin
            len = int'($urandom_range(0, DEPTH - 1));
            run_step(len);
         end
         for (int r = 0; r < 3; r++) rd_cap(int'($urandom_range(0, 31)));
      end

      send(OP_STEP, 3);
      tick();
      chk("rst_step_drv", drv, scr_m[1][8]);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_step_drv0", drv, 0);
      chk("rst_step_halt", halt, 1);
      chk("rst_step_busy", busy, 0);
      chk("rst_step_done", done, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_step_no_done", done, 0);
      end
      send(OP_NOINC, 1);
      chk("noinc_val", no_inc, 1);
      tick();
      chk("noinc_done", done, 1);
      chk("noinc_err", err, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
